video_char_gen: RTL and testbench

- Downstream of the CRTC. Consumes the per-character refresh address (MA), raster row (RA), display enable and syncs.
- Fetches the screen code from video RAM, then the glyph row from character ROM, and serializes it to a 1-bit pixel stream.
- Delays DE/HSYNC/VSYNC by one character slot so they stay aligned with the pixels.
- Sits between the CRTC and the video output pins; memory ports go to the shared RAM arbiter.

---
 rtl/video_char_gen_pkg.sv | 28 ++
 rtl/video_char_gen_if.sv | 27 ++
 rtl/video_char_gen_shift_reg.sv | 31 +++
 rtl/video_char_gen.sv | 165 ++++++++++++++++
 tb/tb_video_char_gen.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/video_char_gen_pkg.sv
// Shared types and constants for the character generator: fetch FSM encoding,
// character ROM geometry and the reverse-video helper.
package video_char_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_VRAM_WAIT = 2'd1,
    ST_CROM_WAIT = 2'd2,
    ST_READY     = 2'd3
  } fetch_state_e;

  localparam int CROM_ADDR_WIDTH = 11;
  localparam int GLYPH_ROWS      = 8;

  // Bit 7 of the screen code inverts the glyph row, but only inside the display window.
  function automatic logic [7:0] apply_reverse(input logic [7:0] pattern,
                                               input logic [7:0] code,
                                               input logic       de);
    logic [7:0] result;
    if (de) begin
      result = pattern ^ {8{code[7]}};
    end else begin
      result = 8'h00;
    end
    return result;
  endfunction

endpackage

// File: rtl/video_char_gen_if.sv
// Memory-side bundle of the character generator: video RAM and character ROM
// request/ack read ports toward the shared RAM arbiter.
interface video_char_gen_if #(
  parameter int VRAM_ADDR_WIDTH = 11
);
  import video_char_gen_pkg::*;

  logic [VRAM_ADDR_WIDTH-1:0] vram_addr;
  logic                       vram_req;
  logic                       vram_ack;
  logic [7:0]                 vram_data;
  logic [CROM_ADDR_WIDTH-1:0] crom_addr;
  logic                       crom_req;
  logic                       crom_ack;
  logic [7:0]                 crom_data;

  modport master (
    output vram_addr, vram_req, crom_addr, crom_req,
    input  vram_ack, vram_data, crom_ack, crom_data
  );

  modport slave (
    input  vram_addr, vram_req, crom_addr, crom_req,
    output vram_ack, vram_data, crom_ack, crom_data
  );

endinterface

// File: rtl/video_char_gen_shift_reg.sv
// Pixel serializer: parallel load at the character strobe (load beats shift),
// MSB-first left shift with zero fill on each pixel strobe.
module video_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             wb_clock_i,
  input  logic             reset_i,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] data_r;

  // Load has priority so the loaded MSB is shown as pixel 0 of the slot
  always_ff @(posedge wb_clock_i) begin
    if (reset_i) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= din;
    end else if (shift) begin
      data_r <= {data_r[WIDTH-2:0], 1'b0};
    end else begin
      data_r <= data_r;
    end
  end

  assign msb = data_r[WIDTH-1];

endmodule

// File: rtl/video_char_gen.sv
// Character generator: screen code fetch, glyph row fetch, pixel serialization
// with one-slot delayed DE/syncs. Define VIDEO_UNDERRUN_COUNT_EN to add underrun_count_o.
module video_char_gen
  import video_char_gen_pkg::*;
#(
  parameter int VRAM_ADDR_WIDTH = 11,
  parameter int CHAR_WIDTH      = 8
) (
  input  logic        wb_clock_i,
  input  logic        reset_i,
  input  logic        char_clk_en_i,
  input  logic        pixel_clk_en_i,
  input  logic [13:0] crtc_ma_i,
  input  logic [4:0]  crtc_ra_i,
  input  logic        crtc_de_i,
  input  logic        crtc_h_sync_i,
  input  logic        crtc_v_sync_i,
  input  logic        gfx_i,
  video_char_gen_if.master mem,
  output logic        video_o,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        de_o,
  output logic        underrun_o
`ifdef VIDEO_UNDERRUN_COUNT_EN
  ,
  output logic [7:0]  underrun_count_o
`endif
);

  fetch_state_e               state_r, state_nx_s;
  logic [VRAM_ADDR_WIDTH-1:0] ma_r;
  logic [4:0]                 ra_r;
  logic                       de_r, hs_r, vs_r, gfx_r;
  logic                       de_q_r, hs_q_r, vs_q_r;
  logic [7:0]                 code_r, pattern_r;
  logic                       vram_req_r, crom_req_r, underrun_r;
  logic                       vram_hit_s, crom_hit_s, underrun_s;
  logic [CHAR_WIDTH-1:0]      load_byte_s;
  logic                       unused_ma_s;

  assign unused_ma_s = ^crtc_ma_i[13:VRAM_ADDR_WIDTH];
  assign vram_hit_s  = vram_req_r & mem.vram_ack;
  assign crom_hit_s  = crom_req_r & mem.crom_ack;

  // Fetch FSM next state; a character strobe restarts the slot from any state
  always_comb begin
    state_nx_s = state_r;
    underrun_s = 1'b0;
    if (char_clk_en_i) begin
      underrun_s = (state_r == ST_VRAM_WAIT) || (state_r == ST_CROM_WAIT);
      state_nx_s = crtc_de_i ? ST_VRAM_WAIT : ST_READY;
    end else begin
      case (state_r)
        ST_VRAM_WAIT: begin
          if (vram_hit_s) begin
            state_nx_s = (ra_r[4:3] == 2'b00) ? ST_CROM_WAIT : ST_READY;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_CROM_WAIT: begin
          if (crom_hit_s) begin
            state_nx_s = ST_READY;
          end else begin
            state_nx_s = state_r;
          end
        end
        default: state_nx_s = state_r;
      endcase
    end
  end

  // Only a completed fetch reaches the pixels; IDLE and missed deadlines show blank
  always_comb begin
    if (state_r == ST_READY) begin
      load_byte_s = apply_reverse(pattern_r, code_r, de_r);
    end else begin
      load_byte_s = {CHAR_WIDTH{1'b0}};
    end
  end

  // State, slot latches and handshakes; an underrun holds requests low for one cycle
  always_ff @(posedge wb_clock_i) begin
    if (reset_i) begin
      state_r    <= ST_IDLE;
      ma_r       <= {VRAM_ADDR_WIDTH{1'b0}};
      ra_r       <= 5'd0;
      de_r       <= 1'b0;
      hs_r       <= 1'b0;
      vs_r       <= 1'b0;
      gfx_r      <= 1'b0;
      de_q_r     <= 1'b0;
      hs_q_r     <= 1'b0;
      vs_q_r     <= 1'b0;
      code_r     <= 8'h00;
      pattern_r  <= 8'h00;
      vram_req_r <= 1'b0;
      crom_req_r <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      vram_req_r <= (state_nx_s == ST_VRAM_WAIT) && !underrun_s;
      crom_req_r <= (state_nx_s == ST_CROM_WAIT);
      if (char_clk_en_i) begin
        ma_r       <= crtc_ma_i[VRAM_ADDR_WIDTH-1:0];
        ra_r       <= crtc_ra_i;
        de_r       <= crtc_de_i;
        hs_r       <= crtc_h_sync_i;
        vs_r       <= crtc_v_sync_i;
        gfx_r      <= gfx_i;
        pattern_r  <= 8'h00;
        de_q_r     <= de_r;
        hs_q_r     <= hs_r;
        vs_q_r     <= vs_r;
        underrun_r <= underrun_r | underrun_s;
      end else begin
        if (vram_hit_s) begin
          code_r <= mem.vram_data;
        end
        if (crom_hit_s) begin
          pattern_r <= mem.crom_data;
        end
      end
    end
  end

`ifdef VIDEO_UNDERRUN_COUNT_EN
  logic [7:0] underrun_cnt_r;

  // Saturating count of missed slot deadlines
  always_ff @(posedge wb_clock_i) begin
    if (reset_i) begin
      underrun_cnt_r <= 8'h00;
    end else if (underrun_s && (underrun_cnt_r != 8'hFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 8'h01;
    end else begin
      underrun_cnt_r <= underrun_cnt_r;
    end
  end

  assign underrun_count_o = underrun_cnt_r;
`endif

  video_shift_reg #(
    .WIDTH (CHAR_WIDTH)
  ) u_shift (
    .wb_clock_i (wb_clock_i),
    .reset_i    (reset_i),
    .load       (char_clk_en_i),
    .shift      (pixel_clk_en_i),
    .din        (load_byte_s),
    .msb        (video_o)
  );

  assign mem.vram_addr = ma_r;
  assign mem.vram_req  = vram_req_r;
  assign mem.crom_addr = {gfx_r, code_r[6:0], ra_r[2:0]};
  assign mem.crom_req  = crom_req_r;
  assign h_sync_o      = hs_q_r;
  assign v_sync_o      = vs_q_r;
  assign de_o          = de_q_r;
  assign underrun_o    = underrun_r;

endmodule

// File: tb/tb_video_char_gen.sv
// Scoreboard bench for video_char_gen: slot-level reference model, memory
// responder with random latency, and a pixel monitor that checks each slot.
module tb_video_char_gen;
  import video_char_gen_pkg::*;

  localparam int SLOT = 16;
  localparam int VRAM_SIZE = 2048;

  typedef struct {
    int ma; int ra; bit de; bit hs; bit vs; bit gfx; bit wv; bit rst; int vlat; int clat;
  } slot_t;
  typedef struct { int pix; int sync; bit und; int cnt; } exp_t;

  logic        wb_clock_i = 1'b0;
  logic        reset_i, char_clk_en_i, pixel_clk_en_i;
  logic [13:0] crtc_ma_i;
  logic [4:0]  crtc_ra_i;
  logic        crtc_de_i, crtc_h_sync_i, crtc_v_sync_i, gfx_i;
  logic        video_o, h_sync_o, v_sync_o, de_o, underrun_o;
`ifdef VIDEO_UNDERRUN_COUNT_EN
  logic [7:0]  underrun_count_o;
`endif

  video_char_gen_if mem();

  video_char_gen dut (
    .wb_clock_i     (wb_clock_i),
    .reset_i        (reset_i),
    .char_clk_en_i  (char_clk_en_i),
    .pixel_clk_en_i (pixel_clk_en_i),
    .crtc_ma_i      (crtc_ma_i),
    .crtc_ra_i      (crtc_ra_i),
    .crtc_de_i      (crtc_de_i),
    .crtc_h_sync_i  (crtc_h_sync_i),
    .crtc_v_sync_i  (crtc_v_sync_i),
    .gfx_i          (gfx_i),
    .mem            (mem),
    .video_o        (video_o),
    .h_sync_o       (h_sync_o),
    .v_sync_o       (v_sync_o),
    .de_o           (de_o),
    .underrun_o     (underrun_o)
`ifdef VIDEO_UNDERRUN_COUNT_EN
    ,
    .underrun_count_o (underrun_count_o)
`endif
  );

  always #5 wb_clock_i = ~wb_clock_i;

  int    vram [VRAM_SIZE];
  int    crom [2048];
  slot_t slots[$];
  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = -1;
  bit    skip_next = 1'b0;
  bit    model_und;
  int    model_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic slot_t mk(int ma, int ra, bit de, bit hs, bit vs, bit gfx,
                               bit wv, bit rst, int vlat, int clat);
    slot_t s;
    s.ma = ma; s.ra = ra; s.de = de; s.hs = hs; s.vs = vs; s.gfx = gfx;
    s.wv = wv; s.rst = rst; s.vlat = vlat; s.clat = clat;
    return s;
  endfunction

  function automatic int glyph_addr(slot_t s);
    return s.gfx * 1024 + (vram[s.ma % VRAM_SIZE] % 128) * 8 + s.ra % 8;
  endfunction

  // Reference: what the pixels and delayed syncs of this slot should look like
  task automatic issue(input slot_t s);
    exp_t e;
    int   code, pat;
    code = vram[s.ma % VRAM_SIZE];
    pat  = (s.ra < GLYPH_ROWS) ? crom[glyph_addr(s)] : 0;
    if (code >= 128) pat = 255 - pat;
    if (!s.de || s.wv) pat = 0;
    if (s.de && s.wv) begin
      model_und = 1'b1;
      if (model_cnt < 255) model_cnt++;
    end
    e.pix = pat; e.sync = s.de * 4 + s.hs * 2 + s.vs;
    e.und = model_und; e.cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_blank();
    exp_t e;
    e.pix = 0; e.sync = 0; e.und = model_und; e.cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  // Driver: one loop iteration per clock cycle, slots of SLOT cycles each
  initial begin
    for (int i = 0; i < VRAM_SIZE; i++) vram[i] = $urandom_range(0, 255);
    for (int i = 0; i < 2048; i++) crom[i] = $urandom_range(0, 255);
    vram[5] = 'h41; vram[6] = 'hC1; vram[7] = 'h80; vram[8] = 'h00;
    crom['h20A] = 'h3C;
    slots.push_back(mk(5, 2, 1, 0, 0, 0, 0, 0, 2, 0));
    slots.push_back(mk(6, 2, 1, 0, 1, 0, 0, 0, 0, 3));
    slots.push_back(mk(7, 9, 1, 0, 0, 0, 0, 0, 1, 0));
    slots.push_back(mk(8, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    slots.push_back(mk(5, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    slots.push_back(mk(5, 2, 1, 0, 0, 0, 1, 0, 0, 0));
    slots.push_back(mk(5, 2, 1, 1, 1, 0, 0, 0, 4, 4));
    for (int i = 0; i < 60; i++) begin
      slots.push_back(mk($urandom_range(0, 16383),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7),
                         $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 9) == 0, 0,
                         $urandom_range(0, 4), $urandom_range(0, 4)));
    end
    slots.push_back(mk($urandom_range(0, 16383), 3, 1, 1, 1, 0, 0, 1, 0, 99));
    for (int i = 0; i < 4; i++) begin
      slots.push_back(mk($urandom_range(0, 16383), $urandom_range(0, 7), 1, 0, 0,
                         1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 4), $urandom_range(0, 4)));
    end
`ifdef VIDEO_UNDERRUN_COUNT_EN
    for (int i = 0; i < 300; i++) slots.push_back(mk(i, 1, 1, 0, 0, 0, 1, 0, 0, 0));
`endif
    slots.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    slots.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    reset_i = 1'b1; char_clk_en_i = 1'b0; pixel_clk_en_i = 1'b0;
    crtc_ma_i = 14'd0; crtc_ra_i = 5'd0; crtc_de_i = 1'b0;
    crtc_h_sync_i = 1'b0; crtc_v_sync_i = 1'b0; gfx_i = 1'b0;
    repeat (3) @(posedge wb_clock_i);
    #1;
    reset_i = 1'b0;
    model_und = 1'b0; model_cnt = 0;
    push_blank();
    for (int s = 0; s < slots.size(); s++) begin
      for (int k = 0; k < SLOT; k++) begin
        cyc = s * SLOT + k;
        char_clk_en_i  = (k == 0);
        pixel_clk_en_i = (k % 2 == 0);
        if (k == 0) begin
          crtc_ma_i = 14'(slots[s].ma); crtc_ra_i = 5'(slots[s].ra);
          crtc_de_i = slots[s].de; crtc_h_sync_i = slots[s].hs;
          crtc_v_sync_i = slots[s].vs; gfx_i = slots[s].gfx;
          issue(slots[s]);
        end
        if (slots[s].rst && k == 4) begin
          reset_i = 1'b1;
          exp_q.delete();
          model_und = 1'b0; model_cnt = 0;
          push_blank();
          skip_next = 1'b1;
        end else begin
          reset_i = 1'b0;
        end
        @(posedge wb_clock_i);
        #1;
      end
    end
    cyc = -1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Memory responder plus request-protocol checks
  int vcnt = 0, ccnt = 0;
  bit vseen = 1'b0, cseen = 1'b0;
  always @(negedge wb_clock_i) begin
    int    rs, ph;
    slot_t sl;
    mem.vram_ack = 1'b0;
    mem.crom_ack = 1'b0;
    if (cyc >= 1) begin
      rs = (cyc - 1) / SLOT;
      ph = (cyc - 1) % SLOT;
      sl = slots[rs];
      if (rs > 0 && slots[rs-1].de && slots[rs-1].wv) begin
        if (ph == 0) check("underrun_req_drop", {mem.vram_req, mem.crom_req}, 0);
        if (ph == 1) check("underrun_refetch", mem.vram_req, sl.de);
      end
      if (mem.vram_req) begin
        vseen = 1'b1;
        if (vcnt == sl.vlat && !sl.wv) begin
          check("vram_addr", mem.vram_addr, sl.ma % VRAM_SIZE);
          mem.vram_ack  = 1'b1;
          mem.vram_data = 8'(vram[mem.vram_addr]);
        end
        vcnt++;
      end else begin
        vcnt = 0;
      end
      if (mem.crom_req) begin
        cseen = 1'b1;
        if (ccnt == sl.clat) begin
          check("crom_addr", mem.crom_addr, glyph_addr(sl));
          mem.crom_ack  = 1'b1;
          mem.crom_data = 8'(crom[mem.crom_addr]);
        end
        ccnt++;
      end else begin
        ccnt = 0;
      end
      if (sl.rst && ph == 4) begin
        check("post_reset_outputs",
              {mem.vram_req, mem.crom_req, video_o, de_o, h_sync_o, v_sync_o, underrun_o}, 0);
`ifdef VIDEO_UNDERRUN_COUNT_EN
        check("post_reset_count", underrun_count_o, 0);
`endif
        mem.vram_ack = 1'b1; mem.crom_ack = 1'b1;
        mem.vram_data = 8'hFF; mem.crom_data = 8'hFF;
      end
      if (sl.rst && ph == 5) check("stray_ack_ignored", {mem.vram_req, mem.crom_req, video_o}, 0);
      if (ph == SLOT - 1) begin
        check("vram_req_seen", vseen, sl.de);
        check("crom_req_seen", cseen, sl.de && sl.ra < 8 && !sl.wv);
        vseen = 1'b0; cseen = 1'b0;
      end
    end
  end

  // Monitor: collect 8 pixels per slot and compare against the scoreboard
  logic [7:0] pix_acc = 8'h00;
  int loads_seen = 0;
  always @(negedge wb_clock_i) begin
    exp_t e;
    if (cyc >= 0) begin
      if (pixel_clk_en_i) pix_acc = {pix_acc[6:0], video_o};
      if (char_clk_en_i) begin
        if (loads_seen > 0) begin
          if (skip_next) begin
            skip_next = 1'b0;
          end else if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at cycle %0d: got output slot, want none", cyc);
          end else begin
            e = exp_q.pop_front();
            check("pixels", pix_acc, e.pix);
            check("de_hs_vs", {de_o, h_sync_o, v_sync_o}, e.sync);
            check("underrun", underrun_o, e.und);
`ifdef VIDEO_UNDERRUN_COUNT_EN
            check("underrun_count", underrun_count_o, e.cnt);
`endif
          end
        end
        loads_seen++;
      end
    end
  end

endmodule
